// File: rtl/nibble_pkg.sv
// Shared sample/word types for the nibble packer and the five-way maximum finder wrapper.
package nibble_pkg;
    localparam int SAMPLE_W = 4;
    localparam int SAMPLES  = 5;
    localparam int WORD_W   = SAMPLE_W * SAMPLES;

    typedef logic [2:0]        cnt_t;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/word_slot.sv
// Single-entry valid/ready output register: loads only when free, so data holds while stalled.
// Latency 1 cycle from load to vld_o; free_o is high when empty or being drained this cycle.
module word_slot
    import nibble_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_i,
    input  word_t load_dat_i,
    input  logic  rdy_i,
    output logic  vld_o,
    output word_t dat_o,
    output logic  free_o
);
    logic  vld_q, vld_d;
    word_t dat_q, dat_d;

    assign free_o = !vld_q || rdy_i;
    assign vld_o  = vld_q;
    assign dat_o  = dat_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load_i) begin
            vld_d = 1'b1;
            dat_d = load_dat_i;
        end else if (vld_q && rdy_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end
endmodule

// File: rtl/nibble_packer.sv
// Packs N W-bit samples (first sample in the top nibble) into one word behind a one-word slot.
// Word valid the cycle after its last sample; in_ready drops only while a second word waits.
module nibble_packer
    import nibble_pkg::*;
#(
    parameter int W = SAMPLE_W,
    parameter int N = SAMPLES
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    output logic           in_ready,
    input  logic           flush,
    output logic           out_valid,
    output logic [N*W-1:0] out_data,
    input  logic           out_ready,
    output logic [2:0]     fill_cnt
);
    word_t asm_q, asm_d;
    cnt_t  fill_q, fill_d;
    logic  full, accept, last, slot_free, load;
    word_t load_dat;

    assign full      = (fill_q == cnt_t'(N));
    assign in_ready  = !full && !flush;
    assign accept    = in_valid && in_ready;
    assign last      = accept && (fill_q == cnt_t'(N - 1));
    assign load      = slot_free && (last || full);
    // A completing sample bypasses the assembly register straight into the slot.
    assign load_dat  = full ? asm_q : {asm_q[WORD_W-1:W], in_data};
    assign fill_cnt  = fill_q;

    always_comb begin
        asm_d  = asm_q;
        fill_d = fill_q;
        if (load || flush) begin
            asm_d  = '0;
            fill_d = '0;
        end else if (accept) begin
            for (int k = 0; k < N; k++) begin
                if (fill_q == cnt_t'(k)) begin
                    asm_d[WORD_W-1-W*k -: W] = in_data;
                end
            end
            fill_d = fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q  <= '0;
            fill_q <= '0;
        end else begin
            asm_q  <= asm_d;
            fill_q <= fill_d;
        end
    end

    word_slot u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .load_dat_i (load_dat),
        .rdy_i      (out_ready),
        .vld_o      (out_valid),
        .dat_o      (out_data),
        .free_o     (slot_free)
    );
endmodule

// File: tb/tb_nibble_packer.sv
module tb_nibble_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_ready = 1'b0;
    logic [2:0]  fill_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .fill_cnt  (fill_cnt)
    );

    typedef struct {
        logic        v;
        logic [3:0]  d;
        logic        f;
        logic        r;
        logic        ir;   // in_ready before the edge
        logic        ov;   // after the edge
        logic [19:0] od;
        logic [2:0]  fc;
    } vec_t;

    vec_t tbl[$];
    logic [3:0] pend[$];   // accepted samples not yet drained from the slot

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [3:0] d, input logic f, input logic r,
                       input logic ir, input logic ov, input logic [19:0] od, input logic [2:0] fc);
        vec_t e;
        e.v = v; e.d = d; e.f = f; e.r = r; e.ir = ir; e.ov = ov; e.od = od; e.fc = fc;
        tbl.push_back(e);
    endtask

    function automatic logic [19:0] head_word();
        return {pend[0], pend[1], pend[2], pend[3], pend[4]};
    endfunction

    initial begin
        int accepted;
        int cycles;
        int s;
        logic exp_ir, acc, drn;

        // Reset-state values
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_fill_cnt", int'(fill_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: 1..5 straight through
        add(1, 4'h1, 0, 1, 1, 0, 20'h00000, 1);
        add(1, 4'h2, 0, 1, 1, 0, 20'h00000, 2);
        add(1, 4'h3, 0, 1, 1, 0, 20'h00000, 3);
        add(1, 4'h4, 0, 1, 1, 0, 20'h00000, 4);
        add(1, 4'h5, 0, 1, 1, 1, 20'h12345, 0);
        // 2: back-to-back words
        add(1, 4'h9, 0, 1, 1, 0, 20'h12345, 1);
        add(1, 4'hA, 0, 1, 1, 0, 20'h12345, 2);
        add(1, 4'hB, 0, 1, 1, 0, 20'h12345, 3);
        add(1, 4'hC, 0, 1, 1, 0, 20'h12345, 4);
        add(1, 4'hD, 0, 1, 1, 1, 20'h9ABCD, 0);
        add(1, 4'hE, 0, 1, 1, 0, 20'h9ABCD, 1);
        add(1, 4'hF, 0, 1, 1, 0, 20'h9ABCD, 2);
        add(1, 4'h0, 0, 1, 1, 0, 20'h9ABCD, 3);
        add(1, 4'h1, 0, 1, 1, 0, 20'h9ABCD, 4);
        add(1, 4'h2, 0, 1, 1, 1, 20'hEF012, 0);
        add(0, 4'h0, 0, 1, 1, 0, 20'hEF012, 0);
        // 3: back-pressure, then one-cycle release
        add(1, 4'h1, 0, 0, 1, 0, 20'hEF012, 1);
        add(1, 4'h2, 0, 0, 1, 0, 20'hEF012, 2);
        add(1, 4'h3, 0, 0, 1, 0, 20'hEF012, 3);
        add(1, 4'h4, 0, 0, 1, 0, 20'hEF012, 4);
        add(1, 4'h5, 0, 0, 1, 1, 20'h12345, 0);
        add(1, 4'h6, 0, 0, 1, 1, 20'h12345, 1);
        add(1, 4'h7, 0, 0, 1, 1, 20'h12345, 2);
        add(1, 4'h8, 0, 0, 1, 1, 20'h12345, 3);
        add(1, 4'h9, 0, 0, 1, 1, 20'h12345, 4);
        add(1, 4'hA, 0, 0, 1, 1, 20'h12345, 5);
        add(1, 4'h0, 0, 0, 0, 1, 20'h12345, 5);
        add(0, 4'h0, 0, 1, 0, 1, 20'h6789A, 0);
        add(0, 4'h0, 0, 0, 1, 1, 20'h6789A, 0);
        // 4: flush blocks a same-cycle sample and clears the partial word
        add(0, 4'h0, 0, 1, 1, 0, 20'h6789A, 0);
        add(1, 4'h7, 0, 1, 1, 0, 20'h6789A, 1);
        add(1, 4'h7, 0, 1, 1, 0, 20'h6789A, 2);
        add(1, 4'h7, 0, 1, 1, 0, 20'h6789A, 3);
        add(1, 4'h3, 1, 1, 0, 0, 20'h6789A, 0);
        add(1, 4'h1, 0, 1, 1, 0, 20'h6789A, 1);
        add(1, 4'h2, 0, 1, 1, 0, 20'h6789A, 2);
        add(1, 4'h3, 0, 1, 1, 0, 20'h6789A, 3);
        add(1, 4'h4, 0, 1, 1, 0, 20'h6789A, 4);
        add(1, 4'h5, 0, 1, 1, 1, 20'h12345, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; flush = tbl[i].f; out_ready = tbl[i].r;
            #1;
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(tbl[i].ir));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(tbl[i].ov));
            chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(tbl[i].od));
            chk($sformatf("vec%0d_fill_cnt", i), int'(fill_cnt), int'(tbl[i].fc));
        end

        // 5: fill to FULL behind a stalled slot, then asynchronous reset
        out_ready = 1'b0; flush = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 4'(i + 6);
            @(posedge clk); #1;
        end
        chk("full_fill_cnt", int'(fill_cnt), 5);
        chk("full_out_valid", int'(out_valid), 1);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_out_data", int'(out_data), 20'h12345);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_fill_cnt", int'(fill_cnt), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 6: random traffic against a sample-queue model
        pend.delete();
        accepted = 0;
        cycles = 0;
        while (accepted < 1000 && cycles < 20000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 2);
            #1;
            s = pend.size();
            exp_ir = (s < 10) && !flush;
            chk("rnd_in_ready", int'(in_ready), int'(exp_ir));
            acc = in_valid && exp_ir;
            drn = (s >= 5) && out_ready;
            @(posedge clk); #1;
            cycles++;
            if (drn) repeat (5) void'(pend.pop_front());
            if (flush) begin
                while (pend.size() > ((pend.size() >= 5) ? 5 : 0)) void'(pend.pop_back());
            end
            if (acc) begin
                pend.push_back(in_data);
                accepted++;
            end
            s = pend.size();
            chk("rnd_out_valid", int'(out_valid), int'(s >= 5));
            chk("rnd_fill_cnt", int'(fill_cnt), (s >= 5) ? s - 5 : s);
            if (s >= 5) chk("rnd_out_data", int'(out_data), int'(head_word()));
        end
        chk("rnd_timeout", int'(accepted >= 1000), 1);

        // Drain what is left
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s = pend.size();
            @(posedge clk); #1;
            if (s >= 5) repeat (5) void'(pend.pop_front());
            s = pend.size();
            chk("drain_out_valid", int'(out_valid), int'(s >= 5));
            if (s >= 5) chk("drain_out_data", int'(out_data), int'(head_word()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nibble_packer.md
# nibble_packer

Streaming packer that collects five 4-bit samples, one per handshake, into the 20-bit packed word consumed by the five-way maximum finder. It sits directly upstream of that finder. It provides:
- a valid/ready input for the sample stream;
- a one-word output slot with valid/ready, so assembly of the next word overlaps the drain of the current one.

## Interface
Parameters:
- `W`, 4: sample width in bits.
- `N`, 5: samples per word. `N*W` must equal 20 for the maximum-finder word.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  sample present on `in_data`.
- `in_data`  in  4  sample.
- `in_ready`  out  1  packer can accept a sample this cycle.
- `flush`  in  1  synchronous discard of the partially assembled word.
- `out_valid`  out  1  `out_data` holds a complete word.
- `out_data`  out  20  packed word. Sample 0 is in `[19:16]`; sample 4 is in `[3:0]`.
- `out_ready`  in  1  consumer takes the word this cycle.
- `fill_cnt`  out  3  number of samples currently held in assembly, 0..5.

## Operation
- A sample is accepted on a rising edge with `in_valid && in_ready`.
- Sample k of a word (k = 0..4) lands in nibble `[19-4k -: 4]` of the assembly register.
- Assembly state, derived from `fill_cnt`:
  - FILL when `fill_cnt` is 0..4. `in_ready=1` unless `flush`=1.
  - FULL when `fill_cnt`=5. `in_ready=0`.
- The output slot is EMPTY (`out_valid=0`) or VALID (`out_valid=1`).
- A slot is "free" this cycle when it is EMPTY, or VALID with `out_ready=1`.
- Transfer into the slot:
  - On acceptance of sample 4 with the slot free: `out_data` loads `{asm[19:4], in_data}` at that edge. `out_valid`=1, `fill_cnt`=0, assembly register cleared.
  - On acceptance of sample 4 with the slot not free: go to FULL and hold.
  - In FULL, on the edge where the slot is free: `out_data` loads from assembly, `out_valid` stays or becomes 1, `fill_cnt`=0.
- Drain: `out_valid && out_ready` with no transfer on the same edge takes the slot to EMPTY. `out_data` keeps its last value.
- `out_data` is stable while `out_valid && !out_ready`.
- `flush`:
  - Clears the assembly register and sets `fill_cnt`=0 at the next edge.
  - A sample presented in the same cycle is not accepted.
  - In FULL, flush discards the held word.
  - Flush never touches the output slot.
  - Flush and a transfer on the same edge: the transfer wins, the word is delivered, and assembly clears either way.
- `in_valid`=0 cycles in the middle of a word are allowed. The partial word is retained indefinitely.

## Timing
- Reset (asynchronous assert): `out_valid`=0, `out_data`=0, `fill_cnt`=0, assembly=0, `in_ready`=1.
- Release on the clock edge is synchronous to `clk`.
- Latency: `out_valid` rises the cycle after the edge accepting sample 4.
- Throughput: one sample per cycle sustained while `out_ready`=1. That gives one word per 5 cycles with no bubbles.
- Back-pressure:
  - With `out_ready`=0, five more samples are accepted after a word is presented. `in_ready` then drops.
  - `in_ready` rises in the cycle after the edge where `out_ready` is seen high.
- `in_ready` is a function of registered state and `flush` only. It never depends on `in_valid`.
- Reset mid-word or mid-hold discards everything. No word is emitted after reset until five new samples arrive.

## Structure
- Shared package `nibble_pkg` holds:
  - `SAMPLE_W`=4, `SAMPLES`=5, `WORD_W`=20;
  - `cnt_t` (3-bit count type);
  - `word_t` (20-bit packed word type).
  - The maximum finder's integration wrapper uses the same package.
- One natural sub-module, `word_slot`: a single-entry valid/ready register with load/drain and stable-hold logic.
- Packing and count logic stay in the top.

## Test plan
1. Reset, then samples 1,2,3,4,5 on consecutive cycles with `out_ready`=1 -> `out_valid`=1 one cycle after the 5th accept, `out_data`=20'h12345, `fill_cnt`=0.
2. Stream 9,A,B,C,D,E,F,0,1,2 with `out_ready`=1 -> words 20'h9ABCD then 20'hEF012, each valid for exactly one cycle, with no `in_ready` gaps.
3. `out_ready`=0 and samples 1..5 then 6..A -> 20'h12345 held stable; `fill_cnt`=5, `in_ready`=0.
   - Raise `out_ready` for one cycle -> next cycle `out_data`=20'h6789A, `in_ready`=1.
4. Samples 7,7,7, then `flush` together with `in_valid`=1 and data 3 -> 3 not taken, `fill_cnt`=0.
   - Then 1,2,3,4,5 -> 20'h12345.
5. `rst_n` pulsed low asynchronously while FULL with a VALID slot -> `out_valid`, `fill_cnt` and `out_data` go to 0 immediately, without a clock edge.
6. Random `in_valid`/`out_ready` over 1000 samples -> the scoreboard sees every 5-sample group delivered once, in order, with the nibble order `[19:16]` first.
